// File: rtl/arith_pkg.sv
// Shared definitions for the serial arithmetic datapath:
// FSM encoding, default operand width and counter sizing.
package arith_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Bit counter width; never below one bit.
  function automatic int cnt_width(input int w);
    int cw;
    cw = $clog2(w);
    return (cw < 1) ? 1 : cw;
  endfunction

endpackage

// File: rtl/full_adder_1.sv
// Single-bit full adder cell used by the serial datapath.
// Purely combinational: sum and majority carry.
module full_adder_1 (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/bit_serial_subtractor.sv
// LSB-first two's-complement subtractor: D = A - B through one
// full-adder cell with a carry flip-flop (A + ~B + 1).
module bit_serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DATA,
  input  logic             LOAD_A,
  input  logic             LOAD_B,
  input  logic             START,
  output logic [WIDTH-1:0] A_Q,
  output logic [WIDTH-1:0] B_Q,
  output logic [WIDTH-1:0] D,
  output logic             OVERFLOW,
  output logic             CARRY,
  output logic             BUSY,
  output logic             DONE
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    cnt;
  logic             c;
  logic             a_msb;
  logic             b_msb;

  logic             nb;
  logic             s;
  logic             co;
  logic [WIDTH-1:0] sr_nxt;

  assign nb     = ~sb[0];
  assign sr_nxt = {s, sr[WIDTH-1:1]};

  full_adder_1 u_fa (
    .a    (sa[0]),
    .b    (nb),
    .cin  (c),
    .s    (s),
    .cout (co)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      A_Q      <= '0;
      B_Q      <= '0;
      D        <= '0;
      OVERFLOW <= 1'b0;
      CARRY    <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      sa       <= '0;
      sb       <= '0;
      sr       <= '0;
      cnt      <= '0;
      c        <= 1'b0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
    end else begin
      if (LOAD_A) A_Q <= DATA;
      if (LOAD_B) B_Q <= DATA;
      DONE <= 1'b0;
      unique case (state)
        IDLE: begin
          if (START) begin
            // Work on private copies so later loads cannot disturb the run.
            sa    <= A_Q;
            sb    <= B_Q;
            a_msb <= A_Q[WIDTH-1];
            b_msb <= B_Q[WIDTH-1];
            c     <= 1'b1;
            cnt   <= '0;
            BUSY  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          sr  <= sr_nxt;
          c   <= co;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            D        <= sr_nxt;
            CARRY    <= co;
            OVERFLOW <= (a_msb ^ b_msb) & (s ^ a_msb);
            DONE     <= 1'b1;
            BUSY     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
